layer4_argmax: RTL and testbench

Sequential classifier stage that consumes the parallel float32 outputs of the layer-4 node bank and reports the index and value of the largest one. It sits directly downstream of the combinational `node4_*` neurons. It captures all node outputs in one handshake, scans them one per cycle with an IEEE-754 single-precision comparator, and presents the winning class through a valid/ready output port.

---
 rtl/layer4_argmax.sv | 121 ++++++++++++
 tb/tb_layer4_argmax.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/layer4_argmax.sv
// Argmax over the layer-4 node bank: captures all float32 node outputs in one
// handshake, scans one element per cycle and reports the winning class/value.
module layer4_argmax #(
    parameter int NUM_IN = 10,
    parameter int IDX_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*NUM_IN-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     out_class,
    output logic [31:0]          out_max,
    output logic                 busy
);

    // state | meaning
    // IDLE  | waiting for a node-output vector, in_ready high
    // SCAN  | comparing buf_q[cnt] against the running best, one per cycle
    // HOLD  | result presented on out_*, waiting for out_ready
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t            state, state_nxt;
    logic [31:0]       buf_q [NUM_IN];
    logic [31:0]       best_val;
    logic [IDX_W-1:0]  best_idx;
    logic [IDX_W-1:0]  cnt;
    logic              accept;
    logic              last;
    logic              replace;
    logic [31:0]       cand;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Sign-magnitude to unsigned key so plain integer compare gives float order;
    // the two zeros are special-cased so they compare equal.
    function automatic logic f32_gt(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ka, kb;
        ka = a[31] ? ~a : (a | 32'h8000_0000);
        kb = b[31] ? ~b : (b | 32'h8000_0000);
        if (is_nan(a))                                return 1'b0;
        if (is_nan(b))                                return 1'b1;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b0;
        return ka > kb;
    endfunction

    assign cand    = buf_q[cnt];
    assign last    = (cnt == IDX_W'(NUM_IN - 1));
    assign replace = (state == SCAN) && f32_gt(cand, best_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (NUM_IN == 1) ? HOLD : SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                buf_q[i] <= 32'h0;
            end
            best_val <= 32'h0;
            best_idx <= '0;
            cnt      <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_IN; i++) begin
                buf_q[i] <= in_data[32*i +: 32];
            end
            best_val <= in_data[31:0];
            best_idx <= '0;
            cnt      <= IDX_W'(1);
        end else if (state == SCAN) begin
            if (replace) begin
                best_val <= cand;
                best_idx <= cnt;
            end
            cnt <= cnt + IDX_W'(1);
        end
    end

    assign out_class = best_idx;
    assign out_max   = best_val;

endmodule

// File: tb/tb_layer4_argmax.sv
// Directed bench for layer4_argmax: hand-computed vectors covering float order,
// NaN/zero/tie rules, backpressure, mid-scan reset and back-to-back offers.
module tb_layer4_argmax;

    localparam int N = 10;
    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [32*N-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_class;
    logic [31:0]      out_max;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;

    layer4_argmax #(.NUM_IN(N), .IDX_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_max   (out_max),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32*N-1:0] fill(input logic [31:0] v);
        logic [32*N-1:0] r;
        for (int i = 0; i < N; i++) r[32*i +: 32] = v;
        return r;
    endfunction

    function automatic logic [32*N-1:0] set_el(input logic [32*N-1:0] vec, input int i,
                                               input logic [31:0] v);
        logic [32*N-1:0] r;
        r = vec;
        r[32*i +: 32] = v;
        return r;
    endfunction

    task automatic scramble();
        for (int i = 0; i < N; i++) in_data[32*i +: 32] = $urandom;
    endtask

    // Present a vector in IDLE; returns #1 after the accept edge.
    task automatic offer(input logic [32*N-1:0] v);
        @(negedge clk);
        chk("in_ready_pre", 32'(in_ready), 32'd1);
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_result(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) chk("timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [32*N-1:0] v,
                       input logic [W-1:0] ec, input logic [31:0] em);
        int n;
        offer(v);
        wait_result(n);
        chk({tag, "_lat"}, 32'(n), 32'd9);
        chk({tag, "_class"}, 32'(out_class), 32'(ec));
        chk({tag, "_max"}, out_max, em);
    endtask

    initial begin
        logic [32*N-1:0] v;
        int n;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_class", 32'(out_class), 32'd0);
        chk("rst_max", out_max, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic max, then backpressure in HOLD
        v = set_el(fill(32'h3F00_0000), 6, 32'h4000_0000);
        run("basic", v, 4'd6, 32'h4000_0000);
        chk("hold_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) begin
                in_data  = set_el(fill(32'h0), 1, 32'h4700_0000);
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_class", 32'(out_class), 32'd6);
            chk("bp_max", out_max, 32'h4000_0000);
        end
        release_out();
        chk("idle_class_hold", 32'(out_class), 32'd6);
        chk("idle_busy", 32'(busy), 32'd0);

        // zeros and ties
        v = set_el(fill(32'h0), 3, 32'h8000_0000);
        run("zeros", v, 4'd0, 32'h0000_0000);
        release_out();
        v = set_el(v, 2, 32'h3F80_0000);
        v = set_el(v, 7, 32'h3F80_0000);
        run("ties", v, 4'd2, 32'h3F80_0000);
        release_out();

        // negatives with NaN at element 0
        v = set_el(fill(32'hBF80_0000), 4, 32'hBF00_0000);
        v = set_el(v, 0, 32'h7FC0_0000);
        run("neg_nan", v, 4'd4, 32'hBF00_0000);
        release_out();

        // +Inf beats a large finite value; -Inf at index 0 loses
        v = set_el(fill(32'h7F00_0000), 8, 32'h7F80_0000);
        v = set_el(v, 0, 32'hFF80_0000);
        run("inf", v, 4'd8, 32'h7F80_0000);
        release_out();

        // reset three cycles after accept
        offer(set_el(fill(32'h3F00_0000), 6, 32'h4000_0000));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_class", 32'(out_class), 32'd0);
        chk("mrst_max", out_max, 32'h0);
        chk("mrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", set_el(fill(32'h3F00_0000), 5, 32'h4040_0000), 4'd5, 32'h4040_0000);
        release_out();

        // back-to-back with out_ready tied high
        @(negedge clk);
        out_ready = 1'b1;
        in_data   = set_el(fill(32'hC000_0000), 9, 32'h4100_0000);
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_a_accept", 32'(busy), 32'd1);
        in_data = set_el(fill(32'h3F80_0000), 1, 32'h4110_0000);
        wait_result(n);
        chk("b2b_a_lat", 32'(n), 32'd9);
        chk("b2b_a_class", 32'(out_class), 32'd9);
        chk("b2b_a_max", out_max, 32'h4100_0000);
        chk("b2b_a_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_idle_valid", 32'(out_valid), 32'd0);
        chk("b2b_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("b2b_b_accept", 32'(busy), 32'd1);
        in_valid = 1'b0;
        scramble();
        out_ready = 1'b0;
        wait_result(n);
        chk("b2b_b_lat", 32'(n), 32'd9);
        chk("b2b_b_class", 32'(out_class), 32'd1);
        chk("b2b_b_max", out_max, 32'h4110_0000);
        release_out();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
